// File: rtl/ebus_xact.sv
// ebus_xact: EBOX-side EBUS transaction sequencer with driver OR-mux, conflict and parity checks.
// Function codes: 0 CONO, 1 CONI, 2 DATAO, 3 DATAI, 4 PIserved, 5 PIaddrIn, 6/7 illegal.
module ebus_xact #(
  parameter int NDRV = 8,
  parameter int DW = 36,
  parameter int TMOW = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [6:0]           reqCS,
  input  logic [2:0]           reqFunc,
  input  logic [DW-1:0]        reqData,
  output logic                 rspValid,
  output logic [DW-1:0]        rspData,
  output logic                 rspTimeout,
  output logic                 rspConflict,
  output logic                 rspNoDrv,
  output logic                 rspParErr,
  output logic                 rspIllegal,
  output logic [6:0]           ebusCS,
  output logic [2:0]           ebusFunc,
  output logic                 ebusDemand,
  output logic [DW-1:0]        ebusDataOut,
  output logic                 ebusDataOutEn,
  input  logic                 ebusAck,
  input  logic                 ebusXfer,
  input  logic                 ebusDataParity,
  input  logic [NDRV*DW-1:0]   drvData,
  input  logic [NDRV-1:0]      drvDriving
);
  localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_DEMAND = 3'd2,
                         S_XFER = 3'd3, S_RELEASE = 3'd4, S_DONE = 3'd5;
  localparam logic [2:0] F_CONO = 3'd0, F_CONI = 3'd1, F_DATAO = 3'd2,
                         F_DATAI = 3'd3, F_PIADDR = 3'd5;
  logic [2:0] state, func_q;
  logic [6:0] cs_q;
  logic [DW-1:0] data_q, bus_data;
  logic [TMOW-1:0] cnt;
  logic active, is_write, is_read, expired, illegal;
  always_comb begin
    bus_data = '0;
    for (int i = 0; i < NDRV; i++) bus_data = bus_data | (drvDriving[i] ? drvData[i*DW +: DW] : '0);
  end
  assign active = state inside {S_SETUP, S_DEMAND, S_XFER, S_RELEASE};
  assign is_write = func_q == F_CONO || func_q == F_DATAO;
  assign is_read = func_q == F_CONI || func_q == F_DATAI || func_q == F_PIADDR;
  assign expired = cnt == TMOW'(TIMEOUT - 1);
  assign illegal = reqFunc[2] & reqFunc[1];
  assign reqReady = state == S_IDLE;
  assign rspValid = state == S_DONE;
  assign ebusCS = active ? cs_q : '0;
  assign ebusFunc = active ? func_q : '0;
  assign ebusDemand = state == S_DEMAND || state == S_XFER;
  assign ebusDataOutEn = active && is_write;
  assign ebusDataOut = ebusDataOutEn ? data_q : '0;
  // The wait counter runs only in the three bus-wait phases and restarts on every phase change.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= S_IDLE;
      cnt <= '0;
      cs_q <= '0;
      func_q <= '0;
      data_q <= '0;
      rspData <= '0;
      rspTimeout <= 1'b0;
      rspConflict <= 1'b0;
      rspNoDrv <= 1'b0;
      rspParErr <= 1'b0;
      rspIllegal <= 1'b0;
    end else begin
      cnt <= (state inside {S_DEMAND, S_XFER, S_RELEASE}) ? cnt + TMOW'(1) : '0;
      case (state)
        S_IDLE: if (reqValid) begin
          cs_q <= reqCS;
          func_q <= reqFunc;
          data_q <= reqData;
          rspData <= '0;
          rspTimeout <= 1'b0;
          rspConflict <= 1'b0;
          rspNoDrv <= 1'b0;
          rspParErr <= 1'b0;
          rspIllegal <= illegal;
          state <= illegal ? S_DONE : S_SETUP;
        end
        S_SETUP: state <= S_DEMAND;
        S_DEMAND: if (ebusAck) begin
          state <= S_XFER;
          cnt <= '0;
        end else if (expired) begin
          state <= S_RELEASE;
          cnt <= '0;
          rspTimeout <= 1'b1;
        end
        S_XFER: if (ebusXfer) begin
          state <= S_RELEASE;
          cnt <= '0;
          if (is_read) begin
            rspData <= bus_data;
            rspConflict <= (drvDriving & (drvDriving - NDRV'(1))) != '0;
            rspNoDrv <= drvDriving == '0;
            rspParErr <= ~^{bus_data, ebusDataParity};
          end
        end else if (expired) begin
          state <= S_RELEASE;
          cnt <= '0;
          rspTimeout <= 1'b1;
        end
        S_RELEASE: if (!ebusAck && !ebusXfer) begin
          state <= S_DONE;
        end else if (expired) begin
          state <= S_DONE;
          rspTimeout <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ebus_xact.sv
// tb_ebus_xact: directed EBUS transactions; a scoreboard queue holds expected responses, a monitor checks them.
module tb_ebus_xact;
  localparam int NDRV = 8, DW = 36;
  logic clk = 0, rstN = 0, reqValid = 0, ebusAck = 0, ebusXfer = 0, ebusDataParity = 0;
  logic [6:0] reqCS = '0;
  logic [2:0] reqFunc = '0;
  logic [DW-1:0] reqData = '0;
  logic [NDRV*DW-1:0] drvData = '0;
  logic [NDRV-1:0] drvDriving = '0;
  logic reqReady, rspValid, rspTimeout, rspConflict, rspNoDrv, rspParErr, rspIllegal;
  logic ebusDemand, ebusDataOutEn;
  logic [DW-1:0] rspData, ebusDataOut, wdata = '0;
  logic [6:0] ebusCS;
  logic [2:0] ebusFunc;
  int n_chk = 0, n_fail = 0, cyc = 0, acc = 0, dcnt = 0, ocnt = 0;
  typedef struct { logic [DW-1:0] data; logic [4:0] flags; int lat; int dem; int oe; } exp_t;
  exp_t sb[$];

  ebus_xact dut (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady), .reqCS(reqCS),
    .reqFunc(reqFunc), .reqData(reqData), .rspValid(rspValid), .rspData(rspData),
    .rspTimeout(rspTimeout), .rspConflict(rspConflict), .rspNoDrv(rspNoDrv),
    .rspParErr(rspParErr), .rspIllegal(rspIllegal), .ebusCS(ebusCS), .ebusFunc(ebusFunc),
    .ebusDemand(ebusDemand), .ebusDataOut(ebusDataOut), .ebusDataOutEn(ebusDataOutEn),
    .ebusAck(ebusAck), .ebusXfer(ebusXfer), .ebusDataParity(ebusDataParity),
    .drvData(drvData), .drvDriving(drvDriving)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [NDRV*DW-1:0] slot(input int i, input logic [DW-1:0] v);
    slot = '0;
    slot[i*DW +: DW] = v;
  endfunction

  // monitor: tracks acceptance cycle, demand and write-drive cycles, then scores each response
  initial forever begin
    @(negedge clk);
    #1;
    if (reqValid && reqReady) begin
      acc = cyc;
      dcnt = 0;
      ocnt = 0;
    end else begin
      if (ebusDemand) dcnt++;
      if (ebusDataOutEn && ebusDataOut == wdata) ocnt++;
    end
    if (rspValid) begin
      chk("rsp_pending", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", 64'(rspData), 64'(e.data));
        chk("rsp_flags", 64'({rspTimeout, rspConflict, rspNoDrv, rspParErr, rspIllegal}), 64'(e.flags));
        chk("rsp_latency", 64'(cyc - acc), 64'(e.lat));
        chk("demand_cycles", 64'(dcnt), 64'(e.dem));
        chk("wdata_cycles", 64'(ocnt), 64'(e.oe));
        chk("done_bus_idle", 64'({ebusCS, ebusFunc, ebusDemand, ebusDataOutEn}), 0);
      end
    end
  end

  // ack_dly < 0: device never responds; same: xfer raised together with ack
  task automatic xact(input logic [2:0] f, input logic [6:0] cs, input logic [DW-1:0] d,
                      input int ack_dly, input logic same, input logic [NDRV-1:0] drv,
                      input logic [NDRV*DW-1:0] dd, input logic par, input logic [DW-1:0] edata,
                      input logic [4:0] eflags, input int lat, input int dem, input int oe);
    int t;
    sb.push_back('{edata, eflags, lat, dem, oe});
    wdata = d;
    reqValid = 1;
    reqFunc = f;
    reqCS = cs;
    reqData = d;
    @(negedge clk);
    reqValid = 0;
    if (ack_dly >= 0) begin
      t = 0;
      while (!ebusDemand && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("demand_seen", 64'(ebusDemand), 1);
      repeat (ack_dly) @(negedge clk);
      ebusAck = 1;
      ebusXfer = same;
      @(negedge clk);
      ebusXfer = 1;
      drvData = dd;
      drvDriving = drv;
      ebusDataParity = par;
      @(negedge clk);
      ebusAck = 0;
      ebusXfer = 0;
      drvDriving = '0;
      drvData = '0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!reqReady && t < 600);
    chk("ready_return", 64'(reqReady), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(reqReady), 1);
    chk("reset_rsp", 64'({rspValid, rspTimeout, rspConflict, rspNoDrv, rspParErr, rspIllegal, rspData}), 0);
    chk("reset_bus", 64'({ebusCS, ebusFunc, ebusDemand, ebusDataOutEn, ebusDataOut}), 0);
    rstN = 1;
    @(negedge clk);
    // DATAI cs=14, driver 3 with odd-parity-correct data (17 ones, parity bit 0)
    xact(3'd3, 7'o14, '0, 0, 0, 8'h08, slot(3, 36'o123456701234), 0, 36'o123456701234, 5'b00000, 5, 2, 0);
    // CONO with ack 10 cycles late; write data driven cycles 1..14
    xact(3'd0, 7'o20, 36'o777, 10, 0, '0, '0, 0, '0, 5'b00000, 15, 12, 14);
    // DATAI with no device: 200 demand cycles, then release, done at cycle 203
    xact(3'd3, 7'o14, '0, -1, 0, '0, '0, 0, '0, 5'b10000, 203, 200, 0);
    // CONI: drivers 1 and 5 give 1|4 = 5 (two ones, parity bit 1 correct)
    xact(3'd1, 7'o4, '0, 0, 0, 8'h22, slot(1, 36'o1) | slot(5, 36'o4), 1, 36'o5, 5'b01000, 5, 2, 0);
    // same with wrong parity bit
    xact(3'd1, 7'o4, '0, 0, 0, 8'h22, slot(1, 36'o1) | slot(5, 36'o4), 0, 36'o5, 5'b01010, 5, 2, 0);
    // illegal functions: done in cycle 1, no demand
    xact(3'd7, 7'o1, '0, -1, 0, '0, '0, 0, '0, 5'b00001, 1, 0, 0);
    xact(3'd6, 7'o1, '0, -1, 0, '0, '0, 0, '0, 5'b00001, 1, 0, 0);
    // DATAI with nobody driving: data 0, parity bit 1 keeps parity good
    xact(3'd3, 7'o14, '0, 2, 0, '0, '0, 1, '0, 5'b00100, 7, 4, 0);
    // DATAO with ack and xfer together: ack consumed first, xfer resampled in XFER
    xact(3'd2, 7'o30, 36'o555000111222, 0, 1, '0, '0, 0, '0, 5'b00000, 5, 2, 4);
    // PIserved is not a read: drivers ignored
    xact(3'd4, 7'o0, '0, 0, 0, 8'h01, slot(0, 36'o7), 0, '0, 5'b00000, 5, 2, 0);
    // reset while in XFER aborts without a response
    reqValid = 1;
    reqFunc = 3'd3;
    reqCS = 7'o14;
    @(negedge clk);
    reqValid = 0;
    @(negedge clk);
    ebusAck = 1;
    @(negedge clk);
    chk("xfer_demand", 64'(ebusDemand), 1);
    ebusAck = 0;
    rstN = 0;
    @(negedge clk);
    chk("abort_state", 64'({reqReady, ebusDemand}), 64'(2'b10));
    rstN = 1;
    repeat (3) @(negedge clk);
    // normal DATAI afterwards, driver 7 data 1 (odd, parity bit 0)
    xact(3'd3, 7'o14, '0, 1, 0, 8'h80, slot(7, 36'o1), 0, 36'o1, 5'b00000, 6, 3, 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
